deadlock_report_unit: RTL and testbench
=======================================

DEADLOCK_REPORT_UNIT -- requirements
Module: deadlock_report_unit

Interface
REQ-001 SHALL have parameter INFO_W, default 4, width of the per-channel block-info vector from the deadlock monitor.
REQ-002 SHALL have parameter STABLE_CYCLES, default 8, consecutive blocked samples required to declare deadlock; legal range 2..65535.
REQ-003 SHALL have parameter CNT_W, default 32, width of the blocked-run cycle counter.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port block  input  1  monitor block flag, sampled every rising edge.
REQ-007 SHALL have port axis_block_info  input  INFO_W  monitor per-channel block info, meaningful only when block=1.
REQ-008 SHALL have port clear  input  1  synchronous single-cycle acknowledge from the testbench.
REQ-009 SHALL have port deadlock  output  1  registered, sticky deadlock declaration.
REQ-010 SHALL have port deadlock_info  output  INFO_W  info snapshot belonging to the declared deadlock.
REQ-011 SHALL have port block_cycles  output  CNT_W  current consecutive-blocked run length.
REQ-012 SHALL have port episode_count  output  16  number of deadlocks declared since reset.
REQ-013 SHALL have port state  output  2  FSM encoding for debug: IDLE=0, SUSPECT=1, DEADLOCK=2; value 3 never driven.

Function
REQ-014 SHALL implement FSM IDLE/SUSPECT/DEADLOCK plus an internal run counter run_cnt (16 bit) and an info snapshot register snap.
REQ-015 IDLE: block=1 -> SUSPECT, run_cnt<=1, snap<=axis_block_info; block=0 -> stay in IDLE.
REQ-016 SUSPECT, block=0 -> IDLE, run_cnt<=0; no episode recorded.
REQ-017 SUSPECT, block=1 with axis_block_info!=snap -> stay in SUSPECT, run_cnt<=1, snap<=axis_block_info (restart the qualification).
REQ-018 SUSPECT, block=1 with axis_block_info==snap and run_cnt==STABLE_CYCLES-1 -> DEADLOCK; deadlock<=1, deadlock_info<=snap, episode_count increments.
REQ-019 SUSPECT, block=1 with axis_block_info==snap and run_cnt<STABLE_CYCLES-1 -> run_cnt increments.
REQ-020 Latency: deadlock SHALL be high immediately after the STABLE_CYCLES-th consecutive rising edge that sampled block=1 with unchanged info.
REQ-021 DEADLOCK SHALL be sticky: deadlock and deadlock_info hold regardless of block and axis_block_info until clear=1 is sampled.
REQ-022 DEADLOCK, clear=1 -> IDLE, deadlock<=0, deadlock_info<=0, run_cnt<=0; clear takes priority over any block value in the same cycle.
REQ-023 clear SHALL be ignored in IDLE and SUSPECT.
REQ-024 If block is still 1 after a clear, the next edge SHALL re-enter SUSPECT per REQ-015 (re-arm; a second episode is possible).
REQ-025 block_cycles SHALL increment on every edge sampling block=1 and load 0 on any edge sampling block=0, independent of FSM state and clear; saturate at all-ones.
REQ-026 episode_count SHALL saturate at 16'hFFFF.
REQ-027 axis_block_info SHALL be ignored whenever block=0.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, deadlock=0, deadlock_info=0, block_cycles=0, episode_count=0, run_cnt=0, snap=0.
REQ-029 Reset asserted mid-SUSPECT or in DEADLOCK SHALL discard the episode in progress; counting restarts only after reset deasserts.
REQ-030 Outputs SHALL be glitch-free registered values; no combinational path from any input to any output.

Verification (STABLE_CYCLES=8, INFO_W=4)
REQ-031 block=1, info=4'hE held for 8 edges -> deadlock=1 after the 8th edge, deadlock_info=4'hE, episode_count=1, block_cycles=8, state=2.
REQ-032 block=1 for 7 edges then 0 -> deadlock never asserts, state returns to 0, block_cycles=0, episode_count=0.
REQ-033 block=1 with info=4'hE for 5 edges, then info=4'hB for 8 edges -> deadlock after the 13th edge, deadlock_info=4'hB.
REQ-034 In DEADLOCK, block drops to 0 for 10 cycles -> deadlock stays 1; then clear=1 for one cycle -> deadlock=0, state=0, deadlock_info=0.
REQ-035 In DEADLOCK with block held at 1 and clear pulsed -> state goes 0 then 1; after 8 further blocked edges deadlock=1 again and episode_count=2.
REQ-036 reset pulled low asynchronously between edges in SUSPECT with run_cnt=6 -> all outputs 0 immediately; after release, 8 fresh blocked edges are needed to assert deadlock.

Source files
------------

// File: rtl/deadlock_report_unit.sv
// Qualifies a monitor's block flag into a sticky deadlock report: block must persist with
// unchanged per-channel info for STABLE_CYCLES edges before deadlock is declared.
module deadlock_report_unit #(
  parameter int          INFO_W        = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int          CNT_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  input  logic              clear,
  output logic              deadlock,
  output logic [INFO_W-1:0] deadlock_info,
  output logic [CNT_W-1:0]  block_cycles,
  output logic [15:0]       episode_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  localparam logic [15:0] LAST_RUN = 16'(STABLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic [INFO_W-1:0]   snap_q, snap_d;
  logic                deadlock_q, deadlock_d;
  logic [INFO_W-1:0]   dl_info_q, dl_info_d;
  logic [CNT_W-1:0]    block_cycles_q, block_cycles_d;
  logic [15:0]         episode_q, episode_d;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    snap_d     = snap_q;
    deadlock_d = deadlock_q;
    dl_info_d  = dl_info_q;
    episode_d  = episode_q;

    unique case (state_q)
      IDLE: begin
        if (block) begin
          state_d   = SUSPECT;
          run_cnt_d = 16'd1;
          snap_d    = axis_block_info;
        end
      end
      SUSPECT: begin
        if (!block) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else if (axis_block_info != snap_q) begin
          // Info changed mid-qualification: restart the run with the new snapshot.
          run_cnt_d = 16'd1;
          snap_d    = axis_block_info;
        end else if (run_cnt_q == LAST_RUN) begin
          state_d    = DEADLOCK;
          deadlock_d = 1'b1;
          dl_info_d  = snap_q;
          if (episode_q != '1) episode_d = episode_q + 16'd1;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
      DEADLOCK: begin
        if (clear) begin
          state_d    = IDLE;
          deadlock_d = 1'b0;
          dl_info_d  = '0;
          run_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running view of the raw block run, unaffected by FSM state or clear.
  always_comb begin
    block_cycles_d = '0;
    if (block) begin
      block_cycles_d = (block_cycles_q == '1) ? block_cycles_q : block_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      run_cnt_q      <= '0;
      snap_q         <= '0;
      deadlock_q     <= 1'b0;
      dl_info_q      <= '0;
      block_cycles_q <= '0;
      episode_q      <= '0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      snap_q         <= snap_d;
      deadlock_q     <= deadlock_d;
      dl_info_q      <= dl_info_d;
      block_cycles_q <= block_cycles_d;
      episode_q      <= episode_d;
    end
  end

  assign deadlock      = deadlock_q;
  assign deadlock_info = dl_info_q;
  assign block_cycles  = block_cycles_q;
  assign episode_count = episode_q;
  assign state         = state_q;

endmodule

// File: tb/tb_deadlock_report_unit.sv
// Bench for deadlock_report_unit: run-length stimulus table with hand-derived expectations,
// scoreboard queue, plus an asynchronous-reset-mid-episode sequence.
module tb_deadlock_report_unit;

  logic        clock;
  logic        reset;
  logic        block;
  logic [3:0]  info;
  logic        clear;
  logic        dl;
  logic [3:0]  dl_info;
  logic [31:0] bc;
  logic [15:0] ep;
  logic [1:0]  st;

  logic        s_dl;
  logic [3:0]  s_info;
  logic [3:0]  s_bc;
  logic [15:0] s_ep;
  logic [1:0]  s_st;

  deadlock_report_unit #(.INFO_W(4), .STABLE_CYCLES(8), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info), .clear(clear),
    .deadlock(dl), .deadlock_info(dl_info), .block_cycles(bc), .episode_count(ep), .state(st)
  );

  // Narrow counter instance so block_cycles saturation is reachable.
  deadlock_report_unit #(.INFO_W(4), .STABLE_CYCLES(2), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info), .clear(clear),
    .deadlock(s_dl), .deadlock_info(s_info), .block_cycles(s_bc), .episode_count(s_ep), .state(s_st)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       b;
    logic [3:0] i;
    logic       c;
    int         reps;
    logic       dl;
    logic [3:0] dinfo;
    logic [1:0] st;
    int         bc;
    int         ep;
  } vec_t;

  typedef struct {
    logic        dl;
    logic [3:0]  dinfo;
    logic [1:0]  st;
    logic [31:0] bc;
    logic [15:0] ep;
    logic [3:0]  bcs;
  } exp_t;

  vec_t tbl[20];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic b, logic [3:0] i, logic c, int reps,
                              logic d, logic [3:0] di, logic [1:0] s, int bcv, int epv);
    vec_t v;
    v.b = b; v.i = i; v.c = c; v.reps = reps;
    v.dl = d; v.dinfo = di; v.st = s; v.bc = bcv; v.ep = epv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic [3:0] i, input logic c);
    @(negedge clock);
    block = b;
    info  = i;
    clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_deadlock"}, 32'(dl), 32'(e.dl));
    chk({tag, "_info"}, 32'(dl_info), 32'(e.dinfo));
    chk({tag, "_state"}, 32'(st), 32'(e.st));
    chk({tag, "_block_cycles"}, bc, e.bc);
    chk({tag, "_episodes"}, 32'(ep), 32'(e.ep));
    chk({tag, "_sat_cycles"}, 32'(s_bc), 32'(e.bcs));
  endtask

  task automatic push_exp(input logic d, input logic [3:0] di, input logic [1:0] s,
                          input int bcv, input int epv);
    exp_t e;
    e.dl = d; e.dinfo = di; e.st = s; e.bc = 32'(bcv); e.ep = 16'(epv);
    e.bcs = (bcv > 15) ? 4'hF : 4'(bcv);
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // b, info, clr, reps -> deadlock, info, state, block_cycles, episodes (after last edge)
    tbl[0]  = mk(1'b0, 4'h0, 1'b0,  2, 1'b0, 4'h0, 2'd0,  0, 0);
    tbl[1]  = mk(1'b1, 4'hE, 1'b0,  7, 1'b0, 4'h0, 2'd1,  7, 0);
    tbl[2]  = mk(1'b1, 4'hE, 1'b0,  1, 1'b1, 4'hE, 2'd2,  8, 1);
    tbl[3]  = mk(1'b0, 4'h5, 1'b0, 10, 1'b1, 4'hE, 2'd2,  0, 1);
    tbl[4]  = mk(1'b1, 4'h3, 1'b0,  3, 1'b1, 4'hE, 2'd2,  3, 1);
    tbl[5]  = mk(1'b0, 4'h0, 1'b1,  1, 1'b0, 4'h0, 2'd0,  0, 1);
    tbl[6]  = mk(1'b0, 4'h0, 1'b1,  2, 1'b0, 4'h0, 2'd0,  0, 1);
    tbl[7]  = mk(1'b1, 4'h7, 1'b0,  7, 1'b0, 4'h0, 2'd1,  7, 1);
    tbl[8]  = mk(1'b0, 4'h7, 1'b0,  1, 1'b0, 4'h0, 2'd0,  0, 1);
    tbl[9]  = mk(1'b1, 4'hE, 1'b0,  5, 1'b0, 4'h0, 2'd1,  5, 1);
    tbl[10] = mk(1'b1, 4'hB, 1'b0,  7, 1'b0, 4'h0, 2'd1, 12, 1);
    tbl[11] = mk(1'b1, 4'hB, 1'b0,  1, 1'b1, 4'hB, 2'd2, 13, 2);
    tbl[12] = mk(1'b1, 4'hB, 1'b1,  1, 1'b0, 4'h0, 2'd0, 14, 2);
    tbl[13] = mk(1'b1, 4'hB, 1'b0,  1, 1'b0, 4'h0, 2'd1, 15, 2);
    tbl[14] = mk(1'b1, 4'hB, 1'b0,  6, 1'b0, 4'h0, 2'd1, 21, 2);
    tbl[15] = mk(1'b1, 4'hB, 1'b0,  1, 1'b1, 4'hB, 2'd2, 22, 3);
    tbl[16] = mk(1'b0, 4'h0, 1'b1,  1, 1'b0, 4'h0, 2'd0,  0, 3);
    tbl[17] = mk(1'b1, 4'h9, 1'b1,  4, 1'b0, 4'h0, 2'd1,  4, 3);
    tbl[18] = mk(1'b1, 4'h9, 1'b0,  4, 1'b1, 4'h9, 2'd2,  8, 4);
    tbl[19] = mk(1'b0, 4'h0, 1'b1,  1, 1'b0, 4'h0, 2'd0,  0, 4);

    reset = 1'b0;
    block = 1'b0;
    info  = 4'h0;
    clear = 1'b0;
    #1;
    push_exp(1'b0, 4'h0, 2'd0, 0, 0);
    check_sb("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        step(tbl[r].b, tbl[r].i, tbl[r].c);
        if (k == tbl[r].reps - 1) begin
          push_exp(tbl[r].dl, tbl[r].dinfo, tbl[r].st, tbl[r].bc, tbl[r].ep);
          check_sb($sformatf("row%0d", r));
        end
      end
    end

    // Asynchronous reset between edges while SUSPECT with run_cnt=6.
    for (int k = 0; k < 6; k++) step(1'b1, 4'hA, 1'b0);
    push_exp(1'b0, 4'h0, 2'd1, 6, 4);
    check_sb("pre_reset");
    #2;
    reset = 1'b0;
    #1;
    push_exp(1'b0, 4'h0, 2'd0, 0, 0);
    check_sb("async_reset");
    step(1'b1, 4'hA, 1'b0);
    push_exp(1'b0, 4'h0, 2'd0, 0, 0);
    check_sb("held_reset");
    @(negedge clock);
    block = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 7; k++) step(1'b1, 4'hA, 1'b0);
    push_exp(1'b0, 4'h0, 2'd1, 7, 0);
    check_sb("rearm7");
    step(1'b1, 4'hA, 1'b0);
    push_exp(1'b1, 4'hA, 2'd2, 8, 1);
    check_sb("rearm8");

    step(1'b0, 4'h0, 1'b0);
    chk("final_sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
